// File: rtl/opb_register_simulink2ppc_snap.sv
// rtl/opb_register_simulink2ppc_snap.sv - OPB slave exposing fabric-pushed words with freshness, overrun and count status
//
// Purpose:
//   User logic pushes 32-bit words with user_valid. The PPC reads them over OPB.
//   Window layout, aliased every 16 bytes:
//     0x0 DATA   (RO)  last captured word
//     0x4 STATUS (RO)  bit31 FRESH, bit30 OVERRUN
//     0x8 COUNT  (RO)  wrapping capture counter
//     0xC CTRL   (WO)  write bit 0 with byte lane 3 enabled to clear OVERRUN and COUNT
//
// Ports:
//   OPB_Clk, OPB_Rst          sole clock, synchronous active-high reset
//   OPB_ABus/BE/DBus/RNW      OPB request, big-endian bit numbering (bit 0 = MSB)
//   OPB_select, OPB_seqAddr   transfer request, burst hint (ignored)
//   Sl_DBus, Sl_xferAck       read data and acknowledge; both zero outside the ack cycle
//   Sl_errAck/retry/toutSup   tied low
//   user_data_in, user_valid  fabric word and its capture strobe
module opb_register_simulink2ppc_snap #(
    parameter logic [31:0] C_BASEADDR   = 32'h01003300,
    parameter logic [31:0] C_HIGHADDR   = 32'h010033FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    input  logic [C_OPB_DWIDTH-1:0]   user_data_in,
    input  logic                      user_valid
);

    localparam int unused_family_bits = $bits(C_FAMILY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    ack_q;
    logic [C_OPB_DWIDTH-1:0] dbus_q;

    logic [C_OPB_DWIDTH-1:0] data_q,    data_d;
    logic                    fresh_q,   fresh_d;
    logic                    overrun_q, overrun_d;
    logic [31:0]             count_q,   count_d;

    logic                    hit;
    logic                    decode;
    logic [1:0]              word_off;
    logic                    data_read;
    logic                    ctrl_clear;
    logic [C_OPB_DWIDTH-1:0] rd_word;
    logic                    unused_inputs;

    assign unused_inputs = ^{OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:30], OPB_ABus[30:31]};

    assign hit      = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
    // Only IDLE decodes, so a select held through ACK/GAP cannot retrigger early.
    assign decode   = (state_q == S_IDLE) && hit;
    assign word_off = OPB_ABus[28:29];

    assign data_read  = decode && OPB_RNW && (word_off == 2'd0);
    assign ctrl_clear = decode && !OPB_RNW && (word_off == 2'd3) && OPB_BE[3] && OPB_DBus[31];

    // Read word is taken from the pre-update register state of the decode cycle.
    always_comb begin
        rd_word = '0;
        case (word_off)
            2'd0:    rd_word = data_q;
            2'd1:    rd_word = {fresh_q, overrun_q, 30'd0};
            2'd2:    rd_word = count_q;
            default: rd_word = '0;
        endcase
    end

    // Capture and clear: a clear in the same cycle as a capture leaves COUNT at 1.
    always_comb begin
        data_d    = data_q;
        fresh_d   = fresh_q;
        overrun_d = overrun_q;
        count_d   = count_q;
        if (user_valid) begin
            data_d  = user_data_in;
            fresh_d = 1'b1;
            count_d = count_q + 32'd1;
            // A concurrent DATA read consumes the old word, so it is not an overrun.
            if (fresh_q && !data_read) begin
                overrun_d = 1'b1;
            end
        end else if (data_read) begin
            fresh_d = 1'b0;
        end
        if (ctrl_clear) begin
            overrun_d = 1'b0;
            count_d   = user_valid ? 32'd1 : 32'd0;
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            data_q    <= '0;
            fresh_q   <= 1'b0;
            overrun_q <= 1'b0;
            count_q   <= '0;
        end else begin
            data_q    <= data_d;
            fresh_q   <= fresh_d;
            overrun_q <= overrun_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            dbus_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ack_q  <= 1'b0;
                    dbus_q <= '0;
                    if (hit) begin
                        state_q <= S_ACK;
                        ack_q   <= 1'b1;
                        dbus_q  <= OPB_RNW ? rd_word : '0;
                    end
                end
                S_ACK: begin
                    state_q <= S_GAP;
                    ack_q   <= 1'b0;
                    dbus_q  <= '0;
                end
                S_GAP: begin
                    state_q <= S_IDLE;
                    ack_q   <= 1'b0;
                    dbus_q  <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                    ack_q   <= 1'b0;
                    dbus_q  <= '0;
                end
            endcase
        end
    end

    // Big-endian bus: dbus_q[31] lands on Sl_DBus[0].
    assign Sl_DBus    = dbus_q;
    assign Sl_xferAck = ack_q;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// tb/tb_opb_register_simulink2ppc_snap.sv - randomized self-checking bench for opb_register_simulink2ppc_snap
module tb_opb_register_simulink2ppc_snap;

    localparam logic [31:0] BASE = 32'h01003300;
    localparam logic [31:0] HIGH = 32'h010033FF;

    logic        OPB_Clk = 1'b0;
    logic        OPB_Rst = 1'b1;
    logic [0:31] OPB_ABus = '0;
    logic [0:3]  OPB_BE = '0;
    logic [0:31] OPB_DBus = '0;
    logic        OPB_RNW = 1'b0;
    logic        OPB_select = 1'b0;
    logic        OPB_seqAddr = 1'b0;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;
    logic [31:0] user_data_in = '0;
    logic        user_valid = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 OPB_Clk = ~OPB_Clk;

    opb_register_simulink2ppc_snap dut (
        .OPB_Clk     (OPB_Clk),
        .OPB_Rst     (OPB_Rst),
        .OPB_ABus    (OPB_ABus),
        .OPB_BE      (OPB_BE),
        .OPB_DBus    (OPB_DBus),
        .OPB_RNW     (OPB_RNW),
        .OPB_select  (OPB_select),
        .OPB_seqAddr (OPB_seqAddr),
        .Sl_DBus     (Sl_DBus),
        .Sl_xferAck  (Sl_xferAck),
        .Sl_errAck   (Sl_errAck),
        .Sl_retry    (Sl_retry),
        .Sl_toutSup  (Sl_toutSup),
        .user_data_in(user_data_in),
        .user_valid  (user_valid)
    );

    // Reference model: the four architectural registers as plain variables.
    logic [31:0] m_data;
    bit          m_fresh;
    bit          m_over;
    logic [31:0] m_count;

    function automatic void model_reset();
        m_data  = 0;
        m_fresh = 0;
        m_over  = 0;
        m_count = 0;
    endfunction

    function automatic void model_capture(logic [31:0] d, bit read_consumes);
        if (m_fresh && !read_consumes) m_over = 1;
        m_data  = d;
        m_fresh = 1;
        m_count = m_count + 1;
    endfunction

    // Returns what the bus should show for a hit transfer, then applies its effects.
    function automatic logic [31:0] model_xfer(bit rnw, logic [1:0] off, logic [0:3] be,
                                               logic [0:31] wd, bit uv, logic [31:0] uvd);
        logic [31:0] rv;
        bit dread;
        bit clr;
        rv = 0;
        if (rnw) begin
            if (off == 0) rv = m_data;
            else if (off == 1) rv = {m_fresh, m_over, 30'd0};
            else if (off == 2) rv = m_count;
        end
        dread = rnw && off == 0;
        clr   = !rnw && off == 3 && be[3] && wd[31];
        if (uv) model_capture(uvd, dread);
        else if (dread) m_fresh = 0;
        if (clr) begin
            m_over  = 0;
            m_count = uv ? 1 : 0;
        end
        return rv;
    endfunction

    task automatic do_reset();
        @(negedge OPB_Clk);
        OPB_Rst = 1;
        OPB_select = 0;
        user_valid = 0;
        @(posedge OPB_Clk);
        @(posedge OPB_Clk);
        #1;
        OPB_Rst = 0;
        model_reset();
    endtask

    task automatic push(input logic [31:0] d);
        @(negedge OPB_Clk);
        user_valid = 1;
        user_data_in = d;
        @(posedge OPB_Clk);
        #1;
        user_valid = 0;
        model_capture(d, 0);
    endtask

    // One OPB transfer; the master holds select until it sees the ack, then drops it.
    // lat: posedges from the request to the ack (0 = none within budget).
    // stray: Sl_DBus nonzero outside the ack cycle, or ack lingering into the gap.
    task automatic xfer(input logic [31:0] addr, input bit rnw, input logic [31:0] wd,
                        input logic [3:0] be, input bit uv, input logic [31:0] uvd,
                        output logic [31:0] rdata, output logic [31:0] expv,
                        output int lat, output bit stray);
        bit hit;
        hit = addr >= BASE && addr <= HIGH;
        rdata = 0;
        lat = 0;
        stray = 0;
        expv = 0;
        @(negedge OPB_Clk);
        OPB_ABus = addr;
        OPB_RNW = rnw;
        OPB_DBus = rnw ? 32'h0 : wd;
        OPB_BE = be;
        OPB_select = 1;
        user_valid = uv;
        user_data_in = uvd;
        for (int k = 1; k <= 4; k++) begin
            @(posedge OPB_Clk);
            #1;
            if (k == 1) user_valid = 0;
            if (Sl_xferAck) begin
                lat = k;
                rdata = Sl_DBus;
                break;
            end
            if (Sl_DBus !== 32'h0) stray = 1;
        end
        if (hit) expv = model_xfer(rnw, addr[3:2], be, wd, uv, uvd);
        else if (uv) model_capture(uvd, 0);
        @(posedge OPB_Clk);
        #1;
        OPB_select = 0;
        if (Sl_xferAck !== 1'b0 || Sl_DBus !== 32'h0) stray = 1;
        @(posedge OPB_Clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd, ex;
        int lat;
        bit stray;
        do_reset();
        tests_run++;
        if (Sl_xferAck !== 1'b0 || Sl_DBus !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: ack=%b dbus=%h required ack=0 dbus=0", Sl_xferAck, Sl_DBus);
        end
        tests_run++;
        if ({Sl_errAck, Sl_retry, Sl_toutSup} !== 3'b000) begin
            tests_failed++;
            $display("FAIL tied_outputs: got %b required 000", {Sl_errAck, Sl_retry, Sl_toutSup});
        end
        for (int o = 0; o < 3; o++) begin
            xfer(BASE + 32'(o * 4), 1, 0, 4'hF, 0, 0, rd, ex, lat, stray);
            tests_run++;
            if (rd !== 32'h0 || lat != 1 || stray) begin
                tests_failed++;
                $display("FAIL reset_read_%0d: data=%h lat=%0d stray=%0d required data=0 lat=1 stray=0", o, rd, lat, stray);
            end
        end
    endtask

    task automatic test_capture();
        logic [31:0] rd, ex;
        int lat;
        bit stray;
        logic [31:0] offs [4] = '{32'h4, 32'h0, 32'h4, 32'h8};
        logic [31:0] want [4] = '{32'h80000000, 32'hDEADBEEF, 32'h0, 32'h1};
        push(32'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            xfer(BASE + offs[i], 1, 0, 4'hF, 0, 0, rd, ex, lat, stray);
            tests_run++;
            if (rd !== want[i] || rd !== ex || lat != 1 || stray) begin
                tests_failed++;
                $display("FAIL capture_read_%0d: got %h lat=%0d required %h (model %h) lat=1", i, rd, lat, want[i], ex);
            end
        end
    endtask

    task automatic test_overrun_clear();
        logic [31:0] rd, ex;
        int lat;
        bit stray;
        do_reset();
        push(32'h1);
        push(32'h2);
        xfer(BASE + 4, 1, 0, 4'hF, 0, 0, rd, ex, lat, stray);
        tests_run++;
        if (rd !== 32'hC0000000 || rd !== ex) begin
            tests_failed++;
            $display("FAIL overrun_status: got %h required C0000000", rd);
        end
        xfer(BASE + 0, 1, 0, 4'hF, 0, 0, rd, ex, lat, stray);
        tests_run++;
        if (rd !== 32'h2 || rd !== ex) begin
            tests_failed++;
            $display("FAIL overrun_data: got %h required 00000002", rd);
        end
        // CTRL with lane 3 disabled must be ignored.
        xfer(BASE + 12, 0, 32'h1, 4'hE, 0, 0, rd, ex, lat, stray);
        tests_run++;
        if (lat != 1 || rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL ctrl_be_write_ack: lat=%0d dbus=%h required lat=1 dbus=0", lat, rd);
        end
        xfer(BASE + 4, 1, 0, 4'hF, 0, 0, rd, ex, lat, stray);
        tests_run++;
        if (rd !== 32'h40000000 || rd !== ex) begin
            tests_failed++;
            $display("FAIL ctrl_be_ignored: got %h required 40000000", rd);
        end
        push(32'h3);
        xfer(BASE + 12, 0, 32'h1, 4'hF, 0, 0, rd, ex, lat, stray);
        xfer(BASE + 4, 1, 0, 4'hF, 0, 0, rd, ex, lat, stray);
        tests_run++;
        if (rd !== 32'h80000000 || rd !== ex) begin
            tests_failed++;
            $display("FAIL clear_status: got %h required 80000000", rd);
        end
        xfer(BASE + 8, 1, 0, 4'hF, 0, 0, rd, ex, lat, stray);
        tests_run++;
        if (rd !== 32'h0 || rd !== ex) begin
            tests_failed++;
            $display("FAIL clear_count: got %h required 00000000", rd);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] rd, ex;
        int lat;
        bit stray;
        xfer(BASE + 0, 1, 0, 4'hF, 0, 0, rd, ex, lat, stray);
        xfer(BASE + 12, 0, 32'h1, 4'hF, 0, 0, rd, ex, lat, stray);
        push(32'h44);
        xfer(BASE + 0, 1, 0, 4'hF, 1, 32'h55, rd, ex, lat, stray);
        tests_run++;
        if (rd !== 32'h44 || rd !== ex) begin
            tests_failed++;
            $display("FAIL sim_read_old: got %h required 00000044", rd);
        end
        xfer(BASE + 4, 1, 0, 4'hF, 0, 0, rd, ex, lat, stray);
        tests_run++;
        if (rd !== 32'h80000000 || rd !== ex) begin
            tests_failed++;
            $display("FAIL sim_status: got %h required 80000000", rd);
        end
        push(32'h66);
        xfer(BASE + 12, 0, 32'h1, 4'hF, 1, 32'h77, rd, ex, lat, stray);
        xfer(BASE + 8, 1, 0, 4'hF, 0, 0, rd, ex, lat, stray);
        tests_run++;
        if (rd !== 32'h1 || rd !== ex) begin
            tests_failed++;
            $display("FAIL sim_clear_count: got %h required 00000001", rd);
        end
        xfer(BASE + 4, 1, 0, 4'hF, 0, 0, rd, ex, lat, stray);
        tests_run++;
        if (rd !== 32'h80000000 || rd !== ex) begin
            tests_failed++;
            $display("FAIL sim_clear_status: got %h required 80000000", rd);
        end
        xfer(BASE + 0, 1, 0, 4'hF, 0, 0, rd, ex, lat, stray);
        tests_run++;
        if (rd !== 32'h77 || rd !== ex) begin
            tests_failed++;
            $display("FAIL sim_clear_data: got %h required 00000077", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ex [3];
        int n_ack;
        push($urandom);
        for (int i = 0; i < 3; i++) ex[i] = model_xfer(1, 0, 4'hF, 0, 0, 0);
        n_ack = 0;
        @(negedge OPB_Clk);
        OPB_ABus = BASE + 32'h20;
        OPB_RNW = 1;
        OPB_BE = 4'hF;
        OPB_select = 1;
        for (int c = 1; c <= 9; c++) begin
            @(posedge OPB_Clk);
            #1;
            tests_run++;
            if (Sl_xferAck !== ((c % 3) == 1)) begin
                tests_failed++;
                $display("FAIL b2b_ack_cycle_%0d: got %b required %b", c, Sl_xferAck, (c % 3) == 1);
            end
            if (Sl_xferAck === 1'b1 && n_ack < 3) begin
                tests_run++;
                if (Sl_DBus !== ex[n_ack]) begin
                    tests_failed++;
                    $display("FAIL b2b_data_%0d: got %h required %h", n_ack, Sl_DBus, ex[n_ack]);
                end
                n_ack++;
            end
        end
        OPB_select = 0;
        @(posedge OPB_Clk);
        #1;
    endtask

    task automatic test_count_wrap();
        logic [31:0] rd, ex;
        int lat;
        bit stray;
        @(negedge OPB_Clk);
        force dut.count_q = 32'hFFFFFFFF;
        @(negedge OPB_Clk);
        release dut.count_q;
        m_count = 32'hFFFFFFFF;
        xfer(BASE + 8, 1, 0, 4'hF, 0, 0, rd, ex, lat, stray);
        tests_run++;
        if (rd !== 32'hFFFFFFFF) begin
            tests_failed++;
            $display("FAIL wrap_preset: got %h required FFFFFFFF", rd);
        end
        xfer(BASE + 0, 1, 0, 4'hF, 0, 0, rd, ex, lat, stray);
        push(32'hA5A5A5A5);
        xfer(BASE + 8, 1, 0, 4'hF, 0, 0, rd, ex, lat, stray);
        tests_run++;
        if (rd !== 32'h0 || rd !== ex) begin
            tests_failed++;
            $display("FAIL wrap_count: got %h required 00000000", rd);
        end
        xfer(BASE + 4, 1, 0, 4'hF, 0, 0, rd, ex, lat, stray);
        tests_run++;
        if (rd !== ex) begin
            tests_failed++;
            $display("FAIL wrap_status: got %h required %h", rd, ex);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, ex, addr, wd;
        logic [3:0] be;
        int lat;
        bit stray, uv;
        int op;
        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 3);
            addr = BASE + 32'($urandom_range(0, 15) * 16) + 32'($urandom_range(0, 3) * 4);
            uv = $urandom_range(0, 2) == 0;
            if (op == 0) begin
                push($urandom);
            end else begin
                wd = (op == 2) ? 32'($urandom_range(0, 1)) : $urandom;
                be = 4'($urandom_range(0, 15));
                if (op == 2) addr[3:2] = 2'd3;
                xfer(addr, op == 1, wd, be, uv, $urandom, rd, ex, lat, stray);
                tests_run++;
                if (rd !== ex || lat != 1 || stray) begin
                    tests_failed++;
                    $display("FAIL random_%0d: addr=%h rnw=%0d got %h lat=%0d stray=%0d required %h lat=1", i, addr, op == 1, rd, lat, stray, ex);
                end
            end
        end
    endtask

    task automatic test_miss_and_reset();
        logic [31:0] rd, ex;
        int lat;
        bit stray;
        xfer(32'h01003400, 1, 0, 4'hF, 0, 0, rd, ex, lat, stray);
        tests_run++;
        if (lat != 0 || stray) begin
            tests_failed++;
            $display("FAIL miss_no_ack: lat=%0d stray=%0d required no ack, dbus 0", lat, stray);
        end
        push(32'h12345678);
        push(32'h9ABCDEF0);
        @(negedge OPB_Clk);
        OPB_ABus = BASE + 4;
        OPB_RNW = 1;
        OPB_select = 1;
        @(posedge OPB_Clk);
        #1;
        tests_run++;
        if (Sl_xferAck !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_pre_ack: got %b required 1", Sl_xferAck);
        end
        OPB_Rst = 1;
        OPB_select = 0;
        @(posedge OPB_Clk);
        #1;
        tests_run++;
        if (Sl_xferAck !== 1'b0 || Sl_DBus !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_mid_ack: ack=%b dbus=%h required ack=0 dbus=0", Sl_xferAck, Sl_DBus);
        end
        OPB_Rst = 0;
        model_reset();
        for (int o = 0; o < 3; o++) begin
            xfer(BASE + 32'(o * 4), 1, 0, 4'hF, 0, 0, rd, ex, lat, stray);
            tests_run++;
            if (rd !== 32'h0 || rd !== ex || lat != 1) begin
                tests_failed++;
                $display("FAIL rst_state_%0d: got %h lat=%0d required 00000000 lat=1", o, rd, lat);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_capture();
        test_overrun_clear();
        test_simultaneous();
        test_back_to_back();
        test_count_wrap();
        test_random();
        test_miss_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
